// File: rtl/alu_pkg.sv
// Shared ALU constants and the saturation-value helper for add_sub.
// ADD_SUB_SAT_EN selects saturating results in add_sub.
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic OP_ADD        = 1'b0;
    localparam logic OP_SUB        = 1'b1;
    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    localparam logic [ALU_W-1:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [ALU_W-1:0] SAT_NEG = 32'h8000_0000;

    // Clamp value for an overflowing result; signed overflow direction follows A's sign.
    function automatic logic [ALU_W-1:0] sat_value(input logic si, input logic d, input logic a_msb);
        logic [ALU_W-1:0] val;
        case ({si, d})
            {MODE_SIGNED, OP_ADD},
            {MODE_SIGNED, OP_SUB}:     val = a_msb ? SAT_NEG : SAT_POS;
            {MODE_UNSIGNED, OP_ADD}:   val = {ALU_W{1'b1}};
            {MODE_UNSIGNED, OP_SUB}:   val = {ALU_W{1'b0}};
            default:                   val = {ALU_W{1'b0}};
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cla_adder32.sv
// Combinational 32-bit carry-lookahead adder built from eight 4-bit lookahead groups.
// Exposes the carry into the MSB (c31) and the carry out (c32) for overflow detection.
module cla_adder32
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             cin,
    output logic [ALU_W-1:0] sum,
    output logic             c31,
    output logic             c32
);

    logic [ALU_W-1:0] g_s;
    logic [ALU_W-1:0] p_s;
    logic [ALU_W:0]   c_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // In-group carries by lookahead; group carry-out from group generate/propagate.
    always_comb begin
        c_s    = {(ALU_W+1){1'b0}};
        c_s[0] = cin;
        for (int k = 0; k < ALU_W / 4; k++) begin
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & c_s[4*k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
            c_s[4*k+4] = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                       | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
        end
    end

    assign sum = p_s ^ c_s[ALU_W-1:0];
    assign c31 = c_s[ALU_W-1];
    assign c32 = c_s[ALU_W];

endmodule

// File: rtl/add_sub.sv
// Registered 32-bit adder/subtractor with carry, sign and overflow flags, one cycle latency.
// Define ADD_SUB_SAT_EN to saturate S on overflow instead of wrapping.
module add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             Si,
    input  logic             D,
    input  logic             Cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             So,
    output logic             V,
    output logic             out_valid
);

    logic [WIDTH-1:0] bx_s;
    logic             c0_s;
    logic [WIDTH-1:0] r_s;
    logic             c31_s;
    logic             c32_s;
    logic [WIDTH-1:0] s_d,    s_q;
    logic             so_d,   so_q;
    logic             v_d,    v_q;
    logic             cout_q;
    logic             valid_q;

    // Subtraction is A + ~B + 1, so Cin is ignored there.
    assign bx_s = (D == OP_ADD) ? B : ~B;
    assign c0_s = (D == OP_ADD) ? Cin : 1'b1;

    cla_adder32 u_cla (
        .a   (A),
        .b   (bx_s),
        .cin (c0_s),
        .sum (r_s),
        .c31 (c31_s),
        .c32 (c32_s)
    );

    // Flag selection by operand nature and operation, then optional clamp.
    always_comb begin
        v_d  = 1'b0;
        so_d = 1'b0;
        s_d  = r_s;
        if (Si == MODE_SIGNED) begin
            v_d  = c31_s ^ c32_s;
            so_d = r_s[WIDTH-1];
        end else if (D == OP_SUB) begin
            v_d  = ~c32_s;
            so_d = ~c32_s;
        end else begin
            v_d  = c32_s;
            so_d = 1'b0;
        end
`ifdef ADD_SUB_SAT_EN
        if (v_d) begin
            s_d = sat_value(Si, D, A[WIDTH-1]);
        end else begin
            s_d = r_s;
        end
`else
        s_d = r_s;
`endif
    end

    // Output registers: load on valid input, otherwise hold data and drop valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= {WIDTH{1'b0}};
            cout_q  <= 1'b0;
            so_q    <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
        end else if (in_valid) begin
            s_q     <= s_d;
            cout_q  <= c32_s;
            so_q    <= so_d;
            v_q     <= v_d;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign So        = so_q;
    assign V         = v_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_add_sub.sv
// Randomized self-checking bench for add_sub against an arithmetic reference model,
// plus hand-computed vectors for the documented cases.
module tb_add_sub;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        so;
        logic        v;
    } res_t;

`ifdef ADD_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        Si = 1'b0;
    logic        D = 1'b0;
    logic        Cin = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic [31:0] S;
    logic        Cout, So, V, out_valid;

    int n_checks = 0;
    int n_errors = 0;

    add_sub dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Si        (Si),
        .D         (D),
        .Cin       (Cin),
        .A         (A),
        .B         (B),
        .S         (S),
        .Cout      (Cout),
        .So        (So),
        .V         (V),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    function automatic res_t calc(input logic si, input logic d, input logic cin,
                                  input logic [31:0] a, input logic [31:0] b);
        res_t   r;
        longint ua, ub, sa, sb, full, sres;
        bit     sovf;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!d) begin
            full   = ua + ub + longint'(cin);
            r.s    = full[31:0];
            r.cout = (full > 64'h0000_0000_FFFF_FFFF);
            sres   = sa + sb + longint'(cin);
        end else begin
            r.s    = a - b;
            r.cout = (ua >= ub);
            sres   = sa - sb;
        end
        sovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        if (si) begin
            r.v  = sovf;
            r.so = r.s[31];
        end else begin
            r.v  = d ? !r.cout : r.cout;
            r.so = d & !r.cout;
        end
        if (SAT && r.v) begin
            if (si) r.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else    r.s = d ? 32'h0000_0000 : 32'hFFFF_FFFF;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    res_t m_r = '0;
    logic m_valid = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r     <= '0;
            m_valid <= 1'b0;
        end else if (in_valid) begin
            m_r     <= calc(Si, D, Cin, A, B);
            m_valid <= 1'b1;
        end else begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("model_S", S, m_r.s);
        chk("model_Cout", {31'd0, Cout}, {31'd0, m_r.cout});
        chk("model_So", {31'd0, So}, {31'd0, m_r.so});
        chk("model_V", {31'd0, V}, {31'd0, m_r.v});
    end

    task automatic drive(input logic si, input logic d, input logic cin,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        Si = si; D = d; Cin = cin; A = a; B = b;
    endtask

    task automatic lit(input string name, input logic si, input logic d, input logic cin,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] s_wrap, input logic [31:0] s_sat,
                       input logic e_cout, input logic e_so, input logic e_v);
        drive(si, d, cin, a, b);
        @(posedge clk); #1;
        chk({name, "_S"}, S, SAT ? s_sat : s_wrap);
        chk({name, "_Cout"}, {31'd0, Cout}, {31'd0, e_cout});
        chk({name, "_So"}, {31'd0, So}, {31'd0, e_so});
        chk({name, "_V"}, {31'd0, V}, {31'd0, e_v});
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [6];
        c[0] = 32'h0000_0000; c[1] = 32'hFFFF_FFFF; c[2] = 32'h8000_0000;
        c[3] = 32'h7FFF_FFFF; c[4] = 32'h0000_0001; c[5] = 32'h8000_0001;
        if ($urandom_range(3) == 0) return c[$urandom_range(5)];
        return $urandom;
    endfunction

    initial begin
        int   vcnt;
        res_t last;
        #1 rst = 1'b1;
        #1;
        chk("reset_S", S, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Documented vectors (Si, D, Cin, A, B)
        lit("uadd_5_3",   1'b0, 1'b0, 1'b1, 32'd5, 32'd3, 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
        lit("uadd_ff_ff", 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        lit("usub_5001",  1'b0, 1'b1, 1'b0, 32'd5001, 32'd3000, 32'd2001, 32'd2001, 1'b1, 1'b0, 1'b0);
        lit("usub_0_15",  1'b0, 1'b1, 1'b1, 32'd0, 32'd15, 32'hFFFF_FFF1, 32'd0, 1'b0, 1'b1, 1'b1);
        lit("sadd_d8f0",  1'b1, 1'b0, 1'b1, 32'hFFFF_D8F0, 32'hFFFF_D8F0,
            32'hFFFF_B1E1, 32'hFFFF_B1E1, 1'b1, 1'b1, 1'b0);
        lit("sadd_neg_ovf", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF6, 32'h8000_0000,
            32'h7FFF_FFF6, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        lit("sadd_pos_ovf", 1'b1, 1'b0, 1'b0, 32'd4, 32'h7FFF_FFFF,
            32'h8000_0003, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        lit("ssub_min",   1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
            32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        lit("ssub_neg_ovf", 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h7FFF_FFFF,
            32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1);
        lit("ssub_pos_ovf", 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFD, 32'hFFFF_FFFD,
            32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1);
        lit("uadd_max_cin", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
        lit("usub_0_max", 1'b0, 1'b1, 1'b0, 32'd0, 32'hFFFF_FFFF,
            32'h0000_0001, 32'd0, 1'b0, 1'b1, 1'b1);
        lit("sadd_0_min", 1'b1, 1'b0, 1'b0, 32'd0, 32'h8000_0000,
            32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset with nonzero outputs, checked before any clock edge
        rst = 1'b1;
        #1;
        chk("async_rst_S", S, 32'd0);
        chk("async_rst_Cout", {31'd0, Cout}, 32'd0);
        chk("async_rst_So", {31'd0, So}, 32'd0);
        chk("async_rst_V", {31'd0, V}, 32'd0);
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Streaming: three back-to-back ops then idle
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd100 * (i + 1), 32'd7);
            @(posedge clk); #1;
            if (out_valid === 1'b1) vcnt++;
        end
        last = calc(1'b0, 1'b0, 1'b0, 32'd300, 32'd7);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) vcnt++;
        end
        chk("stream_valid_cycles", vcnt, 32'd3);
        chk("stream_hold_S", S, last.s);

        // Randomized traffic with a mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b1;
                #1;
                chk("midstream_rst_valid", {31'd0, out_valid}, 32'd0);
            end
            if (i == 1502) rst = 1'b0;
            in_valid = ($urandom_range(3) != 0);
            Si  = $urandom_range(1);
            D   = $urandom_range(1);
            Cin = $urandom_range(1);
            A   = pick();
            B   = pick();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_sub.md
Name: add_sub

Overview:
- 32-bit registered adder/subtractor for the ALU datapath.
- Supports both operand modes: unsigned and signed two's complement.
- Produces sum/difference, carry-out, result sign and overflow.
- One pipeline stage: operands are sampled on a clock edge, results appear one cycle later.

Parameters:
- WIDTH, 32: operand/result width; all behaviour below is stated for the default. Bit WIDTH-1 is the sign bit.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/controls valid this cycle
- Si  input  1  operand nature: 0 = unsigned, 1 = signed two's complement
- D  input  1  operation: 0 = add, 1 = subtract
- Cin  input  1  carry-in, used only when D=0
- A  input  32  first operand
- B  input  32  second operand
- S  output  32  registered result
- Cout  output  1  registered carry-out of the internal adder
- So  output  1  registered result sign
- V  output  1  registered overflow flag
- out_valid  output  1  registered; S/Cout/So/V are valid this cycle

Behaviour:
- Reset: on rst=1, immediately (asynchronous) S=0, Cout=0, So=0, V=0, out_valid=0. Release is sampled at the next rising clk edge.
- Adder operands: Bx = D ? ~B : B; c0 = D ? 1 : Cin. In subtraction Cin is ignored.
- Sum: {c32, R} = A + Bx + c0, computed full width with no truncation before carry extraction. c31 is the carry into bit 31.
- Add (D=0): R = A + B + Cin (mod 2^32).
- Subtract (D=1): R = A − B (mod 2^32).
- Cout = c32 in both operations. For subtract, Cout=1 means no borrow (unsigned A ≥ B).
- Signed mode (Si=1):
  - V = c31 XOR c32, i.e. true signed overflow, including the effect of Cin.
  - So = R[31].
- Unsigned mode (Si=0):
  - Add: V = c32.
  - Subtract: V = ~c32 (borrow).
  - So = D & ~c32; set only for an unsigned subtraction that went negative, otherwise 0.
- Latency: 1 cycle. On a rising clk edge with in_valid=1, S/Cout/So/V load the values computed from that cycle's inputs, and out_valid←1.
- If in_valid=0 at the edge: out_valid←0 and S/Cout/So/V hold their previous values.
- Back-to-back operations every cycle are supported; there is no stall or backpressure.
- Reset asserted mid-stream clears all outputs at once; the in-flight operation is discarded.
- Boundaries:
  - 0xFFFFFFFF+0xFFFFFFFF+1 → S=0xFFFFFFFF, Cout=1.
  - 0−0xFFFFFFFF (unsigned) → S=0x00000001, Cout=0, V=1.
  - 0x00000000+0x80000000 (signed) → S=0x80000000, V=0.
- Combinational core has no latches; all outputs come straight from flops.

Optional Feature:
- Macro ADD_SUB_SAT_EN.
- Defined: when V=1 the registered S saturates instead of wrapping:
  - Signed overflow → 0x7FFFFFFF if A[31]=0, else 0x80000000.
  - Unsigned add overflow → 0xFFFFFFFF.
  - Unsigned subtract borrow → 0x00000000.
  - Cout, V and So are unchanged from the wrapping definitions.
- Not defined: S is the wrapped R; no saturation logic is present.

Decomposition:
- Shared package alu_pkg holds:
  - Constants: ALU_W=32, OP_ADD=1'b0, OP_SUB=1'b1, MODE_UNSIGNED=1'b0, MODE_SIGNED=1'b1.
  - Constants: SAT_POS=32'h7FFFFFFF, SAT_NEG=32'h80000000.
- One natural sub-module: cla_adder32. It is a combinational 32-bit carry-lookahead adder built from 4-bit lookahead groups. It takes a, b, cin and returns sum, c31, c32.
- add_sub owns operand inversion, the flag logic, the optional saturation and the output registers.

Test Plan:
- Reset: assert rst with nonzero registered outputs → S/Cout/So/V/out_valid go 0 immediately, without a clock edge; hold during reset.
- Unsigned add: Si=0 D=0 Cin=1 A=5 B=3 → next cycle S=9, Cout=0, V=0. Then A=B=0xFFFFFFFF Cin=0 → S=0xFFFFFFFE, Cout=1, V=1.
- Unsigned subtract:
  - Si=0 D=1 A=5001 B=3000 → S=2001, Cout=1, V=0, So=0.
  - A=0 B=15 → S=0xFFFFFFF1, Cout=0, V=1, So=1.
- Signed add:
  - Si=1 D=0 Cin=1 A=B=0xFFFFD8F0 → S=0xFFFFB1E1, So=1, V=0.
  - Cin=0 A=0xFFFFFFF6 B=0x80000000 → V=1.
  - Cin=0 A=4 B=0x7FFFFFFF → S=0x80000003, V=1.
- Signed subtract:
  - A=0xFFFFFFFF B=0x7FFFFFFF → S=0x80000000, V=0.
  - A=0xFFFFFFFE B=0x7FFFFFFF → S=0x7FFFFFFF, V=1.
  - A=0x7FFFFFFD B=0xFFFFFFFD → S=0x80000000, V=1. With ADD_SUB_SAT_EN the last result is S=0x7FFFFFFF instead.
- Streaming/valid: issue ops on 3 consecutive cycles, then in_valid=0 → out_valid high for exactly 3 cycles, each result 1 cycle after its inputs, and S holds its last value afterwards.
